// File: rtl/wait_ram.sv
// wait_ram: single-port data memory with byte-lane write enables and a fixed
// number of wait states. Each accepted access completes with a one-cycle
// ready pulse; accesses at or beyond DEPTH complete with err set.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset (memory contents are not reset)
//   ce     - access request, held by the master until ready
//   addr   - word address, sampled at acceptance
//   we     - byte-lane write enables, all zero selects a read
//   din    - write data, lane i is din[8i+7:8i]
//   dout   - registered read data, holds the last read result
//   ready  - one-cycle completion pulse
//   err    - out-of-range flag, meaningful only while ready is high
//   busy   - high while an access is in progress (WAIT or RESP)
module wait_ram #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2,
    localparam int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   we,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);
    // One extra bit so the range compare also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BE_W-1:0]    we_q, we_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               in_range;
    logic               is_read;
    logic               mem_wr;
    logic [IDX_W-1:0]   mem_idx;

    assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
    assign is_read  = (we_q == '0);
    assign mem_idx  = addr_q[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        din_d   = din_q;
        dout_d  = dout_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_wr  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ce) begin
                    addr_d  = addr;
                    we_d    = we;
                    din_d   = din;
                    cnt_d   = LAT_CNT;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    state_d = StResp;
                    if (!in_range) begin
                        // Out-of-range writes are dropped; reads return zero.
                        err_d = 1'b1;
                        if (is_read) begin
                            dout_d = '0;
                        end
                    end else if (is_read) begin
                        dout_d = mem[mem_idx];
                    end else begin
                        mem_wr = 1'b1;
                    end
                end
            end
            StResp: begin
                // ce is deliberately ignored here so a held request is not replayed.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            we_q    <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset; mem_wr is low while in reset since state_q is idle.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (we_q[i]) begin
                    mem[mem_idx][8*i +: 8] <= din_q[8*i +: 8];
                end
            end
        end
    end

    assign dout  = dout_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: doc/wait_ram.md
# wait_ram

Parametrised single-port data memory with byte-lane write enables and a configurable wait-state latency, reporting completion through a `ready` pulse. It replaces the zero-wait data RAM on the MIPS32 core's data port (`dce`/`daddr`/`we`/`din`/`dm`) so the core's stall logic can be exercised against slow memory. It also adds an out-of-range error response for non-power-of-two depths.

## Interface
- `DATA_W`, 32: data width; multiple of 8. `BE_W = DATA_W/8` byte lanes.
- `DEPTH`, 1024: number of words; any value from 1 to 2^`ADDR_W`.
- `ADDR_W`, 10: word-address width.
- `LATENCY`, 2: wait states, 0..15.

- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  access request; held by the master until `ready`.
- `addr`  in  `ADDR_W`  word address.
- `we`  in  `BE_W`  byte-lane write enables; all zero means a read.
- `din`  in  `DATA_W`  write data; lane i is `din[8i+7:8i]`.
- `dout`  out  `DATA_W`  read data; registered.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  out-of-range flag; valid only while `ready`=1.
- `busy`  out  1  high in WAIT and RESP.

## Operation
- States: IDLE, WAIT, RESP. A 4-bit down-counter `cnt` runs in WAIT.
- **IDLE:** when `ce`=1, latch `addr`, `we` and `din`, load `cnt`=`LATENCY`, and go to WAIT. When `ce`=0, stay in IDLE.
- **WAIT:** when `cnt`≠0, decrement `cnt`.
- **WAIT, `cnt`=0:** execute the latched access, set `ready`=1, and go to RESP.
  - In-range read: `dout` gets `mem[addr]`.
  - In-range write: write each lane whose `we` bit is set; other lanes keep their value; `dout` is unchanged.
  - Out of range (`addr` ≥ `DEPTH`): drop the write; on a read, `dout` gets 0; set `err`=1.
- **RESP:** `ready` and `err` return to 0 and the state returns to IDLE. `ce` is ignored in RESP, so a master still holding `ce` does not retrigger the access.
- Inputs are sampled only at acceptance. Changes to `addr`, `we` or `din` during WAIT or RESP have no effect.
- Memory contents are not reset; they hold their values across `rst_n`. Simulation initial contents are X.

## Timing
- Reset (asynchronous):
  - Outputs: `dout`=0, `ready`=0, `err`=0, `busy`=0.
  - Internal: state=IDLE, `cnt`=0.
- Acceptance happens at edge E0. The access executes at edge E(`LATENCY`+1), and `ready`/`dout`/`err` are valid during the cycle after that edge. `ready` drops at edge E(`LATENCY`+2).
- Earliest next acceptance is edge E(`LATENCY`+3) if `ce` is high then. Throughput is one access per `LATENCY`+3 cycles.
- `LATENCY`=0: `ready` is high in the second cycle after acceptance.
- `busy` rises after E0 and falls after E(`LATENCY`+2).
- Reset in WAIT: the access is aborted, no write takes place, and `ready` never pulses.
- Reset in RESP: `ready` is cleared immediately, and a write already executed remains in memory.
- Between accesses, `dout` holds the last read result (or 0 after reset or after an out-of-range read).

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle → `dout`=0, `ready`=0, `err`=0, `busy`=0 immediately, without waiting for `clk`.
- **Full-word write then read, `LATENCY`=2:**
  - Write `addr`=5, `we`=4'hF, `din`=32'hDEADBEEF, holding `ce` → `ready` is high in the 4th cycle after acceptance, and `ce` still held in RESP causes no second access.
  - Read `addr`=5 → `dout`=32'hDEADBEEF with `ready`, `err`=0.
- **Byte-lane write:** write `we`=4'b0101, `din`=32'h11223344 to `addr`=5 → a subsequent read returns 32'hDE22BE44.
- **Out of range, `DEPTH`=1000:**
  - Write to `addr`=1000 → `ready`=1 and `err`=1, memory unchanged.
  - Read `addr`=1023 → `dout`=0, `err`=1.
  - Read `addr`=999 → `err`=0.
- **Reset mid-WAIT:** start a write of 32'hCAFEF00D to `addr`=7, then pulse `rst_n` low one cycle after acceptance → no `ready` pulse, and a later read of `addr`=7 returns its prior value.
- **`LATENCY`=0 instance, back-to-back:** hold `ce` with the master changing `addr` after each `ready` → `ready` pulses every 3 cycles and reads return the correct data for each address.
